// File: rtl/score_sequencer.sv
// Song-level controller around the shared ScoreConversion datapath: takes one judgement
// pair per note event, weights the converted score by a combo multiplier and accumulates it.
module score_sequencer #(
    parameter int SCORE_W   = 24,
    parameter int COMBO_W   = 10,
    parameter int MULT_STEP = 10,
    parameter int MAX_MULT  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               game_start,
    input  logic               game_end,
    input  logic               judge_valid,
    input  logic [1:0]         judge_up,
    input  logic [1:0]         judge_down,
    output logic               judge_ready,
    output logic [1:0]         conv_up,
    output logic [1:0]         conv_down,
    input  logic [15:0]        conv_score,
    output logic [SCORE_W-1:0] total_score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output logic [2:0]         multiplier,
    output logic               done
);

    localparam int PROD_W = 19;
    localparam int SUM_W  = ((SCORE_W > PROD_W) ? SCORE_W : PROD_W) + 1;
    localparam int CSUM_W = COMBO_W + 1;
    localparam int STEP_W = $clog2(MULT_STEP + 2) + 1;

    localparam logic [1:0]        J_PERFECT  = 2'b00;
    localparam logic [1:0]        J_GOOD     = 2'b01;
    localparam logic [1:0]        J_MISS     = 2'b10;
    localparam logic [1:0]        J_NO_NOTE  = 2'b11;
    localparam logic [2:0]        MULT_ONE   = 3'd1;
    localparam logic [2:0]        MULT_CAP   = 3'(MAX_MULT);
    localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MULT_STEP);
    localparam logic [SUM_W-1:0]  TOTAL_MAX  = {{(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAY    = 3'd1,
        CONVERT = 3'd2,
        ACCUM   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t              state_r;
    logic [PROD_W-1:0]   product_r;
    logic [1:0]          hits_r;
    logic                miss_r;
    logic                end_pending_r;
    logic [STEP_W-1:0]   step_r;

    logic [1:0]          hits_s;
    logic                miss_s;
    logic [SUM_W-1:0]    total_sum_s;
    logic [SCORE_W-1:0]  total_next_s;
    logic [CSUM_W-1:0]   combo_sum_s;
    logic [COMBO_W-1:0]  combo_next_s;
    logic [COMBO_W-1:0]  max_next_s;
    logic [STEP_W-1:0]   step_sum_s;
    logic [STEP_W-1:0]   step_next_s;
    logic [2:0]          mult_next_s;

    function automatic logic is_hit(input logic [1:0] j);
        return (j == J_PERFECT) || (j == J_GOOD);
    endfunction

    function automatic logic is_miss(input logic [1:0] j);
        return (j == J_MISS);
    endfunction

    // Classify the pair currently presented to ScoreConversion (valid only in CONVERT)
    always_comb begin
        hits_s = {1'b0, is_hit(conv_up)} + {1'b0, is_hit(conv_down)};
        miss_s = is_miss(conv_up) || is_miss(conv_down);
    end

    // Next totals, combo and multiplier applied on the ACCUM edge
    always_comb begin
        total_sum_s = SUM_W'(total_score) + SUM_W'(product_r);
        if (total_sum_s > TOTAL_MAX) begin
            total_next_s = {SCORE_W{1'b1}};
        end else begin
            total_next_s = total_sum_s[SCORE_W-1:0];
        end

        combo_sum_s  = {1'b0, combo} + CSUM_W'(hits_r);
        step_sum_s   = step_r + STEP_W'(hits_r);
        combo_next_s = combo;
        step_next_s  = step_r;
        mult_next_s  = multiplier;
        if (miss_r) begin
            combo_next_s = {COMBO_W{1'b0}};
            step_next_s  = {STEP_W{1'b0}};
            mult_next_s  = MULT_ONE;
        end else begin
            combo_next_s = combo_sum_s[COMBO_W] ? {COMBO_W{1'b1}} : combo_sum_s[COMBO_W-1:0];
            // Step keeps wrapping at the cap so the multiplier never needs to look back
            if (step_sum_s >= STEP_LIMIT) begin
                step_next_s = step_sum_s - STEP_LIMIT;
                mult_next_s = (multiplier < MULT_CAP) ? (multiplier + 3'd1) : multiplier;
            end else begin
                step_next_s = step_sum_s;
                mult_next_s = multiplier;
            end
        end

        max_next_s = (combo_next_s > max_combo) ? combo_next_s : max_combo;
    end

    // Sequencing FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            judge_ready   <= 1'b0;
            conv_up       <= J_NO_NOTE;
            conv_down     <= J_NO_NOTE;
            total_score   <= {SCORE_W{1'b0}};
            combo         <= {COMBO_W{1'b0}};
            max_combo     <= {COMBO_W{1'b0}};
            multiplier    <= MULT_ONE;
            done          <= 1'b0;
            product_r     <= {PROD_W{1'b0}};
            hits_r        <= 2'd0;
            miss_r        <= 1'b0;
            end_pending_r <= 1'b0;
            step_r        <= {STEP_W{1'b0}};
        end else if (game_start) begin
            state_r       <= PLAY;
            judge_ready   <= 1'b1;
            conv_up       <= J_NO_NOTE;
            conv_down     <= J_NO_NOTE;
            total_score   <= {SCORE_W{1'b0}};
            combo         <= {COMBO_W{1'b0}};
            max_combo     <= {COMBO_W{1'b0}};
            multiplier    <= MULT_ONE;
            done          <= 1'b0;
            product_r     <= {PROD_W{1'b0}};
            hits_r        <= 2'd0;
            miss_r        <= 1'b0;
            end_pending_r <= 1'b0;
            step_r        <= {STEP_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    judge_ready <= 1'b0;
                    done        <= 1'b0;
                end
                PLAY: begin
                    if (judge_valid && judge_ready) begin
                        conv_up       <= judge_up;
                        conv_down     <= judge_down;
                        judge_ready   <= 1'b0;
                        end_pending_r <= game_end;
                        state_r       <= CONVERT;
                    end else if (game_end) begin
                        judge_ready <= 1'b0;
                        done        <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        judge_ready <= 1'b1;
                    end
                end
                CONVERT: begin
                    product_r     <= PROD_W'(conv_score) * PROD_W'(multiplier);
                    hits_r        <= hits_s;
                    miss_r        <= miss_s;
                    end_pending_r <= end_pending_r || game_end;
                    conv_up       <= J_NO_NOTE;
                    conv_down     <= J_NO_NOTE;
                    state_r       <= ACCUM;
                end
                ACCUM: begin
                    total_score <= total_next_s;
                    combo       <= combo_next_s;
                    max_combo   <= max_next_s;
                    step_r      <= step_next_s;
                    multiplier  <= mult_next_s;
                    if (end_pending_r || game_end) begin
                        judge_ready <= 1'b0;
                        done        <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        judge_ready <= 1'b1;
                        state_r     <= PLAY;
                    end
                end
                DONE: begin
                    judge_ready <= 1'b0;
                    done        <= 1'b1;
                end
                default: begin
                    judge_ready <= 1'b0;
                    conv_up     <= J_NO_NOTE;
                    conv_down   <= J_NO_NOTE;
                    done        <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_sequencer.sv
// Drives two sequencers (24-bit and 12-bit totals) with shared stimulus against a
// song-level scoring model and a ScoreConversion stub per instance.
module tb_score_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        game_start = 1'b0;
    logic        game_end = 1'b0;
    logic        judge_valid = 1'b0;
    logic [1:0]  judge_up = 2'b11;
    logic [1:0]  judge_down = 2'b11;

    logic        ready_a, ready_b, done_a, done_b;
    logic [1:0]  conv_up_a, conv_down_a, conv_up_b, conv_down_b;
    logic [15:0] score_a, score_b;
    logic [23:0] total_a;
    logic [11:0] total_b;
    logic [9:0]  combo_a, max_a, combo_b, max_b;
    logic [2:0]  mult_a, mult_b;

    int checks = 0;
    int errors = 0;

    int m_total_a = 0;
    int m_total_b = 0;
    int m_hits = 0;
    int m_max = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] stub(input logic [1:0] u, input logic [1:0] d);
        int s;
        s = 0;
        if (u == 2'b00) s += 100; else if (u == 2'b01) s += 50;
        if (d == 2'b00) s += 100; else if (d == 2'b01) s += 50;
        return 16'(s);
    endfunction

    assign score_a = stub(conv_up_a, conv_down_a);
    assign score_b = stub(conv_up_b, conv_down_b);

    score_sequencer #(.SCORE_W(24), .COMBO_W(10), .MULT_STEP(10), .MAX_MULT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .game_start(game_start), .game_end(game_end),
        .judge_valid(judge_valid), .judge_up(judge_up), .judge_down(judge_down),
        .judge_ready(ready_a), .conv_up(conv_up_a), .conv_down(conv_down_a),
        .conv_score(score_a), .total_score(total_a), .combo(combo_a),
        .max_combo(max_a), .multiplier(mult_a), .done(done_a)
    );

    score_sequencer #(.SCORE_W(12), .COMBO_W(10), .MULT_STEP(10), .MAX_MULT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .game_start(game_start), .game_end(game_end),
        .judge_valid(judge_valid), .judge_up(judge_up), .judge_down(judge_down),
        .judge_ready(ready_b), .conv_up(conv_up_b), .conv_down(conv_down_b),
        .conv_score(score_b), .total_score(total_b), .combo(combo_b),
        .max_combo(max_b), .multiplier(mult_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Multiplier and combo both follow the hit count since the last miss or start.
    function automatic int model_mult();
        int m;
        m = 1 + m_hits / 10;
        return (m > 4) ? 4 : m;
    endfunction

    function automatic int model_combo();
        return (m_hits > 1023) ? 1023 : m_hits;
    endfunction

    task automatic model_reset();
        m_total_a = 0;
        m_total_b = 0;
        m_hits = 0;
        m_max = 0;
    endtask

    task automatic model_event(input logic [1:0] u, input logic [1:0] d);
        int perf, good, add;
        perf = int'(u == 2'b00) + int'(d == 2'b00);
        good = int'(u == 2'b01) + int'(d == 2'b01);
        add = (100 * perf + 50 * good) * model_mult();
        m_total_a = (m_total_a + add > 16777215) ? 16777215 : m_total_a + add;
        m_total_b = (m_total_b + add > 4095) ? 4095 : m_total_b + add;
        if (u == 2'b10 || d == 2'b10) m_hits = 0;
        else m_hits += perf + good;
        if (model_combo() > m_max) m_max = model_combo();
    endtask

    task automatic check_model(input string tag, input logic ended);
        chk({tag, ".total_a"}, 32'(total_a), m_total_a);
        chk({tag, ".total_b"}, 32'(total_b), m_total_b);
        chk({tag, ".combo_a"}, 32'(combo_a), model_combo());
        chk({tag, ".combo_b"}, 32'(combo_b), model_combo());
        chk({tag, ".max_a"}, 32'(max_a), m_max);
        chk({tag, ".mult_a"}, 32'(mult_a), model_mult());
        chk({tag, ".mult_b"}, 32'(mult_b), model_mult());
        chk({tag, ".ready"}, 32'(ready_a), 32'(!ended));
        chk({tag, ".done"}, 32'(done_a), 32'(ended));
        chk({tag, ".done_b"}, 32'(done_b), 32'(ended));
    endtask

    // mode 0: no end, 1: game_end at the accept edge, 2: game_end while in CONVERT
    task automatic send(input logic [1:0] u, input logic [1:0] d, input int mode, input string tag);
        int n;
        n = 0;
        while (!ready_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready_wait"}, 32'(ready_a), 32'd1);
        judge_valid = 1'b1;
        judge_up = u;
        judge_down = d;
        game_end = (mode == 1);
        @(negedge clk);
        judge_valid = 1'b0;
        judge_up = 2'b11;
        judge_down = 2'b11;
        game_end = (mode == 2);
        chk({tag, ".ready_c1"}, 32'(ready_a), 32'd0);
        chk({tag, ".conv_up"}, 32'(conv_up_a), 32'(u));
        chk({tag, ".conv_down"}, 32'(conv_down_a), 32'(d));
        chk({tag, ".conv_up_b"}, 32'(conv_up_b), 32'(u));
        @(negedge clk);
        game_end = 1'b0;
        chk({tag, ".ready_c2"}, 32'(ready_a), 32'd0);
        chk({tag, ".conv_idle"}, 32'({conv_up_a, conv_down_a}), 32'hF);
        model_event(u, d);
        @(negedge clk);
        check_model(tag, mode != 0);
    endtask

    task automatic pulse_start(input logic with_end);
        game_start = 1'b1;
        game_end = with_end;
        @(negedge clk);
        game_start = 1'b0;
        game_end = 1'b0;
        model_reset();
    endtask

    initial begin
        // Reset values and ignored valid in IDLE
        repeat (2) @(negedge clk);
        chk("rst.ready", 32'(ready_a), 32'd0);
        chk("rst.conv", 32'({conv_up_a, conv_down_a}), 32'hF);
        chk("rst.total", 32'(total_a), 32'd0);
        chk("rst.mult", 32'(mult_a), 32'd1);
        chk("rst.done", 32'(done_a), 32'd0);
        chk("rst.combo", 32'(combo_a), 32'd0);
        rst_n = 1'b1;
        judge_valid = 1'b1;
        judge_up = 2'b00;
        judge_down = 2'b00;
        repeat (4) @(negedge clk);
        chk("idle.ready", 32'(ready_a), 32'd0);
        chk("idle.conv", 32'({conv_up_a, conv_down_a}), 32'hF);
        chk("idle.total", 32'(total_a), 32'd0);
        judge_valid = 1'b0;

        // Single perfect lane
        pulse_start(1'b0);
        chk("start.ready", 32'(ready_a), 32'd1);
        chk("start.done", 32'(done_a), 32'd0);
        send(2'b00, 2'b11, 0, "single");
        chk("single.total_k", 32'(total_a), 32'd100);
        chk("single.combo_k", 32'(combo_a), 32'd1);

        // Multiplier ramp
        pulse_start(1'b0);
        for (int i = 0; i < 10; i++) begin
            send(2'b00, 2'b00, 0, "ramp");
            if (i == 4) chk("ramp.mult5_k", 32'(mult_a), 32'd2);
        end
        chk("ramp.total_k", 32'(total_a), 32'd3000);
        chk("ramp.combo_k", 32'(combo_a), 32'd20);
        chk("ramp.mult_k", 32'(mult_a), 32'd3);

        // Miss uses the old multiplier, then resets combo
        send(2'b10, 2'b00, 0, "miss");
        chk("miss.total_k", 32'(total_a), 32'd3300);
        chk("miss.combo_k", 32'(combo_a), 32'd0);
        chk("miss.mult_k", 32'(mult_a), 32'd1);
        chk("miss.max_k", 32'(max_a), 32'd20);

        // Random judgements
        for (int i = 0; i < 40; i++) begin
            send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0, "rand");
        end

        // game_end during CONVERT finishes the event, then DONE ignores valids
        send(2'b01, 2'b00, 2, "end_conv");
        judge_valid = 1'b1;
        judge_up = 2'b00;
        repeat (4) @(negedge clk);
        check_model("done_hold", 1'b1);
        chk("done_hold.conv", 32'({conv_up_a, conv_down_a}), 32'hF);
        judge_valid = 1'b0;
        pulse_start(1'b0);
        check_model("restart", 1'b0);
        chk("restart.max_k", 32'(max_a), 32'd0);

        // game_end coincident with accept
        send(2'b00, 2'b01, 1, "end_acc");

        // Start wins over simultaneous end (from DONE), then saturate the 12-bit total
        pulse_start(1'b1);
        check_model("start_end_done", 1'b0);
        for (int i = 0; i < 25; i++) send(2'b00, 2'b00, 0, "sat");
        chk("sat.total_b_k", 32'(total_b), 32'd4095);

        // Start wins over simultaneous end (from PLAY)
        pulse_start(1'b1);
        check_model("start_end_play", 1'b0);

        // game_start in CONVERT discards the in-flight event
        send(2'b00, 2'b00, 0, "pre_abort");
        judge_valid = 1'b1;
        judge_up = 2'b00;
        judge_down = 2'b00;
        @(negedge clk);
        judge_valid = 1'b0;
        pulse_start(1'b0);
        chk("abort.conv", 32'({conv_up_a, conv_down_a}), 32'hF);
        @(negedge clk);
        check_model("abort", 1'b0);
        send(2'b00, 2'b11, 0, "post_abort");

        // Async reset mid-event
        judge_valid = 1'b1;
        judge_up = 2'b01;
        judge_down = 2'b01;
        @(negedge clk);
        judge_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst.ready", 32'(ready_a), 32'd0);
        chk("arst.conv", 32'({conv_up_a, conv_down_a}), 32'hF);
        chk("arst.total", 32'(total_a), 32'd0);
        chk("arst.mult", 32'(mult_a), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst.idle_ready", 32'(ready_a), 32'd0);
        chk("arst.idle_done", 32'(done_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_sequencer.md
# score_sequencer

Controller that sequences the shared ScoreConversion datapath during a song. Accepts one judgement pair (up lane, down lane) per note event through a valid/ready handshake and drives the pair into ScoreConversion. It samples the returned 16-bit score, weights it by a combo-driven multiplier and accumulates a saturating song total. It also tracks current combo, max combo and game start/end state for the display and result screens.

## Interface
Parameters:
- SCORE_W, 24, width of accumulated total_score
- COMBO_W, 10, width of combo and max_combo counters
- MULT_STEP, 10, hits needed per multiplier increment
- MAX_MULT, 4, multiplier ceiling (≥1, ≤7)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- game_start  input  1  one-cycle pulse: clear totals, enter PLAY
- game_end  input  1  one-cycle pulse: finish song
- judge_valid  input  1  judgement pair present
- judge_up  input  2  up-lane judgement: 00 PERFECT, 01 GOOD, 10 MISS, 11 NO_NOTE
- judge_down  input  2  down-lane judgement, same encoding
- judge_ready  output  1  block can accept a pair this cycle
- conv_up  output  2  to ScoreConversion judgement_up
- conv_down  output  2  to ScoreConversion judgement_down
- conv_score  input  16  from ScoreConversion score (combinational from conv_up/down)
- total_score  output  SCORE_W  accumulated weighted score
- combo  output  COMBO_W  current consecutive-hit count
- max_combo  output  COMBO_W  highest combo this song
- multiplier  output  3  current weight, 1..MAX_MULT
- done  output  1  high in DONE state

## Operation
- States: IDLE, PLAY, CONVERT, ACCUM, DONE.
- IDLE: after reset. judge_ready=0. game_start → PLAY.
- PLAY: judge_ready=1. Handshake at an edge where judge_valid&judge_ready → latch pair, go to CONVERT. game_end with no accept → DONE. game_end coincident with accept → accept, finish event, then DONE.
- CONVERT: conv_up/conv_down = latched pair. Register product = conv_score × multiplier (19 bits). Latch hit/miss classification. → ACCUM.
- ACCUM: total_score += product, saturating at 2^SCORE_W−1. Update combo, step counter and multiplier. Go to DONE if game_end was seen during or at the start of the event, else PLAY.
- DONE: done=1, judge_ready=0, outputs hold. Only game_start leaves.
- Outside CONVERT, conv_up=conv_down=NO_NOTE (11).
- Combo rules per event:
  - hits = number of lanes with PERFECT or GOOD (0..2).
  - Any MISS lane → combo=0, step counter=0, multiplier=1.
  - Otherwise combo += hits, saturating at all-ones. step += hits; when step ≥ MULT_STEP, step −= MULT_STEP and multiplier +1, capped at MAX_MULT.
  - Both lanes NO_NOTE → no change except adding product (0).
- max_combo = max(max_combo, new combo), updated in ACCUM.
- Product uses the multiplier value from before the event.
- game_start in any state (including CONVERT/ACCUM) has priority over everything:
  - Next state PLAY.
  - total, combo, max_combo, step cleared; multiplier=1; any in-flight event discarded.
  - Wins over a simultaneous game_end.

## Timing
- Reset values: state IDLE, judge_ready=0, conv_up=conv_down=11, total_score=0, combo=0, max_combo=0, multiplier=1, done=0. rst_n low mid-event aborts the event immediately (async).
- Accept at edge E0 → CONVERT during cycle after E0 → product registered at E1 → ACCUM → totals visible after E2 → judge_ready=1 again after E2.
- Throughput: one event per 3 cycles; judge_ready low exactly 2 cycles per event.
- judge_valid while judge_ready=0 is ignored; the source holds it.

## Test plan
Bench uses a ScoreConversion stub: conv_score = 100 per PERFECT lane + 50 per GOOD lane.
- Reset: rst_n low then high → judge_ready=0, conv=11/11, total 0, multiplier 1, done 0. Valid with no game_start is not accepted.
- game_start, then (PERFECT, NO_NOTE) → judge_ready low 2 cycles, conv=00/11 for one cycle, total=100, combo=1, multiplier=1.
- From fresh start, 10 × (PERFECT, PERFECT) → multiplier 2 after event 5. Final total=3000, combo=20, multiplier=3.
- Then (MISS, PERFECT) → total=3300 (old multiplier 3), combo=0, multiplier=1, max_combo=20.
- game_end pulsed during CONVERT → event completes (total updated), then done=1, judge_ready=0. Later valids ignored. game_start → all cleared, PLAY.
- SCORE_W=12, MAX_MULT=4: repeated (PERFECT, PERFECT) → total saturates at 4095, never wraps. game_start coincident with game_end → PLAY, done=0.
